// File: rtl/status_flag_register_if.sv
// Execute-stage ALU/flag bus between the pipeline and the NZCV status flag register.
// The master drives the operation and control strobes; the slave returns the result and the flag views.
interface status_flag_register_if #(
  parameter int DATA_W = 32
);
  logic              exe_valid;
  logic              exe_s;
  logic [3:0]        exe_cmd;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              stall;
  logic              flush;
  logic              exc_take;
  logic              exc_ret;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        sr;
  logic [3:0]        sr_fwd;
  logic [3:0]        sr_saved;

  modport master (
    output exe_valid, exe_s, exe_cmd, op_a, op_b, stall, flush, exc_take, exc_ret,
    input  alu_res, sr, sr_fwd, sr_saved
  );

  modport slave (
    input  exe_valid, exe_s, exe_cmd, op_a, op_b, stall, flush, exc_take, exc_ret,
    output alu_res, sr, sr_fwd, sr_saved
  );
endinterface

// File: rtl/status_flag_register.sv
// Computes the NZCV flags from the execute-stage ALU operation and commits them to SR[3:0] (3=N 2=Z 1=C 0=V).
// It also provides a same-cycle bypass of the next SR value and a single-entry saved copy for exceptions.
module status_flag_register #(
  parameter int         DATA_W = 32,
  parameter logic [3:0] RST_SR = 4'b0000
) (
  input logic                   clk,
  input logic                   rst_n,
  status_flag_register_if.slave bus
);

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } cmd_e;

  cmd_e              cmd;
  logic [3:0]        sr_q;
  logic [3:0]        saved_q;
  logic [DATA_W-1:0] b_eff;
  logic              c_in_eff;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              is_arith;
  logic              cmd_ok;
  logic              flag_c;
  logic              flag_v;
  logic [3:0]        new_flags;
  logic              commit;
  logic [3:0]        fwd;

  assign cmd = cmd_e'(bus.exe_cmd);

  // Subtraction is a + ~b + carry, so C=1 means no borrow and one adder covers all four forms.
  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    b_eff    = bus.op_b;
    c_in_eff = 1'b0;
    is_arith = 1'b0;
    cmd_ok   = 1'b1;
    res      = '0;
    case (cmd)
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin is_arith = 1'b1; c_in_eff = sr_q[1]; end
      CMD_SUB: begin is_arith = 1'b1; b_eff = ~bus.op_b; c_in_eff = 1'b1; end
      CMD_SBC: begin is_arith = 1'b1; b_eff = ~bus.op_b; c_in_eff = sr_q[1]; end
      CMD_MOV: res = bus.op_b;
      CMD_MVN: res = ~bus.op_b;
      CMD_AND: res = bus.op_a & bus.op_b;
      CMD_ORR: res = bus.op_a | bus.op_b;
      CMD_EOR: res = bus.op_a ^ bus.op_b;
      default: cmd_ok = 1'b0;
    endcase
    sum = {1'b0, bus.op_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, c_in_eff};
    if (is_arith) res = sum[DATA_W-1:0];
  end

  // Logical ops preserve C and V; overflow looks at the effective addends, not the raw operands.
  assign flag_c    = is_arith ? sum[DATA_W] : sr_q[1];
  assign flag_v    = is_arith ? ((bus.op_a[DATA_W-1] == b_eff[DATA_W-1]) &&
                                 (res[DATA_W-1] != bus.op_a[DATA_W-1]))
                              : sr_q[0];
  assign new_flags = {res[DATA_W-1], (res == '0), flag_c, flag_v};

  assign commit = bus.exe_valid & bus.exe_s & ~bus.stall & ~bus.flush & cmd_ok;
  assign fwd    = bus.exc_ret ? saved_q : (commit ? new_flags : sr_q);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= RST_SR;
      saved_q <= 4'b0000;
    end else begin
      sr_q <= fwd;
      // A simultaneous return keeps the saved copy intact; otherwise capture the post-commit value.
      if (bus.exc_take && !bus.exc_ret) saved_q <= fwd;
    end
  end

  assign bus.alu_res  = res;
  assign bus.sr       = sr_q;
  assign bus.sr_fwd   = fwd;
  assign bus.sr_saved = saved_q;

endmodule

// File: tb/tb_status_flag_register.sv
// Directed bench for status_flag_register: hand-computed NZCV vectors covering arithmetic, logical,
// gating, bypass, exception save/restore and asynchronous reset.
module tb_status_flag_register;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  status_flag_register_if #(.DATA_W(DATA_W)) bus ();

  status_flag_register #(.DATA_W(DATA_W), .RST_SR(4'b0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    bus.exe_valid = v;
    bus.exe_s     = s;
    bus.exe_cmd   = c;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.exc_take  = 1'b0;
    bus.exc_ret   = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op_check(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic [3:0] exp_sr);
    drive(1'b1, 1'b1, c, a, b);
    #1;
    check({tag, "_res"}, bus.alu_res, exp_res);
    tick();
    check({tag, "_sr"}, {28'h0, bus.sr}, {28'h0, exp_sr});
  endtask

  initial begin
    idle();
    #12;
    check("rst_sr", {28'h0, bus.sr}, 32'h0);
    check("rst_saved", {28'h0, bus.sr_saved}, 32'h0);
    check("rst_fwd", {28'h0, bus.sr_fwd}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Load nonzero state so the asynchronous reset has something to clear.
    op_check("pre_add", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);
    idle();
    bus.exc_take = 1'b1;
    tick();
    check("pre_saved", {28'h0, bus.sr_saved}, 32'h9);

    // Reset mid-cycle with a commit pending.
    drive(1'b1, 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_sr", {28'h0, bus.sr}, 32'h0);
    check("rst_mid_saved", {28'h0, bus.sr_saved}, 32'h0);
    tick();
    check("rst_hold_sr", {28'h0, bus.sr}, 32'h0);
    rst_n = 1'b1;
    op_check("first_add", 4'b0010, 32'h1, 32'h1, 32'h2, 4'b0000);

    // Overflow and wrap-around.
    op_check("ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);
    op_check("wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110);

    // Subtract / compare / subtract-with-carry.
    op_check("sub_eq", 4'b0100, 32'h5, 32'h5, 32'h0, 4'b0110);
    op_check("sub_neg", 4'b0100, 32'h3, 32'h5, 32'hFFFF_FFFE, 4'b1000);
    op_check("sbc_c0", 4'b0101, 32'h5, 32'h2, 32'h2, 4'b0010);

    // Gating: stall, flush, both, S=0, no-op code; sr stays 0010.
    drive(1'b1, 1'b1, 4'b0010, 32'h0, 32'h0);
    bus.stall = 1'b1;
    #1;
    check("stall_fwd", {28'h0, bus.sr_fwd}, 32'h2);
    tick();
    check("stall_sr", {28'h0, bus.sr}, 32'h2);
    drive(1'b1, 1'b1, 4'b0010, 32'h0, 32'h0);
    bus.flush = 1'b1;
    tick();
    check("flush_sr", {28'h0, bus.sr}, 32'h2);
    drive(1'b1, 1'b1, 4'b0010, 32'h0, 32'h0);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    tick();
    check("stfl_sr", {28'h0, bus.sr}, 32'h2);
    drive(1'b1, 1'b0, 4'b0010, 32'h0, 32'h0);
    tick();
    check("nos_sr", {28'h0, bus.sr}, 32'h2);
    op_check("nop", 4'b1111, 32'h1234, 32'h5678, 32'h0, 4'b0010);

    // Logical ops preserve C/V; ADC consumes C.
    op_check("cv_set", 4'b0010, 32'h8000_0000, 32'h8000_0001, 32'h1, 4'b0011);
    op_check("eor", 4'b1000, 32'hA5, 32'hA5, 32'h0, 4'b0111);
    op_check("adc_c1", 4'b0011, 32'h1, 32'h1, 32'h3, 4'b0000);
    op_check("mvn", 4'b1001, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'b1000);
    op_check("mov", 4'b0001, 32'h0, 32'h0, 32'h0, 4'b0100);
    op_check("orr", 4'b0111, 32'hF0, 32'h0F, 32'hFF, 4'b0000);
    op_check("and", 4'b0110, 32'hF0, 32'h0F, 32'h0, 4'b0100);

    // Bypass: back-to-back flag-setting ops, sr lags sr_fwd by one cycle.
    drive(1'b1, 1'b1, 4'b0100, 32'h3, 32'h5);
    #1;
    check("byp1_fwd", {28'h0, bus.sr_fwd}, 32'h8);
    check("byp1_sr", {28'h0, bus.sr}, 32'h4);
    tick();
    drive(1'b1, 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'h1);
    #1;
    check("byp2_fwd", {28'h0, bus.sr_fwd}, 32'h6);
    check("byp2_sr", {28'h0, bus.sr}, 32'h8);
    tick();
    check("byp2_post", {28'h0, bus.sr}, 32'h6);

    // Exception save / restore.
    op_check("sr1010", 4'b0100, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 4'b1010);
    idle();
    bus.exc_take = 1'b1;
    tick();
    check("take_saved", {28'h0, bus.sr_saved}, 32'hA);
    op_check("exc_sub", 4'b0100, 32'h7, 32'h7, 32'h0, 4'b0110);
    drive(1'b1, 1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1);
    bus.exc_ret = 1'b1;
    #1;
    check("ret_fwd", {28'h0, bus.sr_fwd}, 32'hA);
    tick();
    check("ret_sr", {28'h0, bus.sr}, 32'hA);
    op_check("clr", 4'b0010, 32'h1, 32'h1, 32'h2, 4'b0000);
    drive(1'b1, 1'b1, 4'b0100, 32'h5, 32'h5);
    bus.exc_take = 1'b1;
    bus.exc_ret  = 1'b1;
    tick();
    check("both_sr", {28'h0, bus.sr}, 32'hA);
    check("both_saved", {28'h0, bus.sr_saved}, 32'hA);
    drive(1'b1, 1'b1, 4'b0100, 32'h3, 32'h5);
    bus.exc_take = 1'b1;
    tick();
    check("take_cmt_sr", {28'h0, bus.sr}, 32'h8);
    check("take_cmt_saved", {28'h0, bus.sr_saved}, 32'h8);

    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/status_flag_register.md
Name: status_flag_register

Overview:
- Producer side of the NZCV condition flags consumed by the decode-stage condition checker.
- Computes N/Z/C/V from the execute-stage ALU operation, commits them to the architectural status register when the S-bit is set, and exposes SR[3:0] in the checker's bit order: 3=N, 2=Z, 1=C, 0=V.
- Also provides a same-cycle bypass value and a single-entry saved copy for exception entry/return.

Parameters:
- DATA_W, 32, ALU operand/result width.
- RST_SR, 4'b0000, SR value loaded on reset.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- exe_valid  input  1  execute-stage instruction valid.
- exe_s  input  1  instruction's S-bit (update flags).
- exe_cmd  input  4  ALU command: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB/CMP, 0101 SBC, 0110 AND/TST, 0111 ORR, 1000 EOR; all other codes are no-op.
- op_a  input  DATA_W  ALU operand A (Rn).
- op_b  input  DATA_W  ALU operand B (shifter output).
- stall  input  1  pipeline hold; blocks commit.
- flush  input  1  squash the execute-stage instruction.
- exc_take  input  1  exception entry: save SR.
- exc_ret  input  1  exception return: restore saved SR.
- alu_res  output  DATA_W  combinational ALU result.
- sr  output  4  committed status register.
- sr_fwd  output  4  bypass: the value sr will hold next cycle.
- sr_saved  output  4  saved copy.

Behaviour:
- Reset (asynchronous, rst_n=0): sr=RST_SR, sr_saved=4'b0000. alu_res and sr_fwd are combinational and follow from the reset sr.
- Arithmetic (DATA_W+1 bit internal sum; c_in is the committed sr[1]):
  - ADD: res=a+b.
  - ADC: res=a+b+c_in.
  - SUB: res=a-b, computed as a+~b+1.
  - SBC: res=a+~b+c_in.
  - C = carry out of bit DATA_W-1; for SUB/SBC, C=1 means no borrow.
  - V = signed overflow: both effective addends share a sign and the result sign differs.
- Logical (MOV=b, MVN=~b, AND, ORR, EOR): N and Z are updated; C and V are preserved from sr.
- N=res[DATA_W-1]; Z=(res==0). No-op codes produce res=0 and no flag change even if exe_s=1.
- Commit condition: exe_valid & exe_s & ~stall & ~flush & valid cmd. When true, sr <= new flags at the rising edge (latency 1). Otherwise sr holds.
- sr_fwd = commit ? new flags : sr. The decode-stage checker uses sr_fwd for back-to-back flag dependency (zero bubble).
- Exception entry (exc_take=1): sr_saved <= sr_fwd, i.e. the committed value including any same-cycle commit.
- Exception return (exc_ret=1): sr <= sr_saved. This overrides a same-cycle commit; sr_fwd shows sr_saved that cycle.
- exc_take and exc_ret both high: the restore wins for sr; sr_saved <= the pre-edge sr_saved (no change).
- Priority on sr each edge: exc_ret > commit > hold.
- flush and stall both high: no commit.
- Reset mid-operation: all state returns to reset values immediately; no partial commit.
- Wrap-around:
  - 0xFFFFFFFF+1 -> res 0, Z=1, C=1, V=0.
  - 0x7FFFFFFF+1 -> N=1, V=1, C=0.

Test Plan:
- Reset: rst_n=0 mid-cycle with pending commit -> sr=0000, sr_saved=0000 immediately; after release, first ADD S=1 a=1 b=1 -> sr=0000 next edge.
- Overflow/wrap: ADD S=1 a=0x7FFFFFFF b=1 -> sr=1001. Then ADD a=0xFFFFFFFF b=1 -> sr=0110.
- Subtract/compare: SUB S=1 a=5 b=5 -> sr=0110. SUB a=3 b=5 -> sr=1000. SBC a=5 b=2 with C=0 -> res=2, sr=0010.
- Gating: ADD S=1 a=0 b=0 with stall=1 -> sr unchanged, sr_fwd=sr. Same with flush=1 -> unchanged. exe_s=0 -> unchanged. Logical EOR a=b=0xA5 S=1 with prior C=1, V=1 -> sr=0111.
- Bypass: two back-to-back flag-setting ops -> sr_fwd equals each op's flags in its own cycle; sr lags by 1.
- Exception: sr=1010; exc_take=1 -> sr_saved=1010. Then SUB a=b -> sr=0110. Then exc_ret=1 with a concurrent ADD S=1 -> sr=1010 (restore wins). exc_take with exc_ret together -> sr_saved unchanged.
